// File: rtl/fnd_display_scheduler.sv
// Page scheduler for a 4-digit FND showing DHT temperature/humidity, with an error page.
// Optional stale-data flag is built only when FND_SCHED_STALE_EN is defined.
module fnd_display_scheduler #(
    parameter int CLK_PER_MS = 100000,
    parameter int PAGE_MS    = 2000,
    parameter int ERR_MS     = 3000,
    parameter int STALE_MS   = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_valid,
    input  logic       dht_err,
    input  logic [7:0] humidity_inc,
    input  logic [7:0] humidity_dec,
    input  logic [7:0] temperature_inc,
    input  logic [7:0] temperature_dec,
    input  logic       btn_next,
    input  logic       hold,
    output logic [7:0] disp_hi,
    output logic [7:0] disp_lo,
    output logic [1:0] page,
    output logic       blank,
    output logic       stale
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_TEMP = 2'd1,
        ST_HUM  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int PW   = $clog2(CLK_PER_MS + 1);
    localparam int TMAX = (PAGE_MS > ERR_MS) ? PAGE_MS : ERR_MS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_MS - 1);
    localparam logic [TW-1:0] PAGE_LAST = TW'(PAGE_MS - 1);
    localparam logic [TW-1:0] ERR_LAST  = TW'(ERR_MS - 1);

    function automatic logic [7:0] sat99(input logic [7:0] v);
        return (v > 8'd99) ? 8'd99 : v;
    endfunction

    logic [PW-1:0] pre_cnt_reg;
    logic          ms_tick;

    assign ms_tick = (pre_cnt_reg == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pre_cnt_reg <= '0;
        else if (ms_tick)
            pre_cnt_reg <= '0;
        else
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
    end

    // A valid pulse is only accepted when no error arrives in the same cycle.
    logic accept;
    assign accept = dht_valid && !dht_err;

    // Snapshot slots: 0 temp int, 1 temp dec, 2 hum int, 3 hum dec.
    logic [7:0] data_in   [4];
    logic [7:0] snap_reg  [4];
    logic [7:0] snap_next [4];

    assign data_in[0] = temperature_inc;
    assign data_in[1] = temperature_dec;
    assign data_in[2] = humidity_inc;
    assign data_in[3] = humidity_dec;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap
            assign snap_next[gi] = accept ? data_in[gi] : snap_reg[gi];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    snap_reg[gi] <= '0;
                else
                    snap_reg[gi] <= snap_next[gi];
            end
        end
    endgenerate

    state_t        state_reg, state_next;
    state_t        ret_reg, ret_next;
    logic [TW-1:0] tmr_reg, tmr_next;
    logic [7:0]    err_cnt_reg, err_cnt_next;
    logic          page_expire;

    always_comb begin
        state_next   = state_reg;
        ret_next     = ret_reg;
        tmr_next     = tmr_reg;
        err_cnt_next = err_cnt_reg;
        page_expire  = ms_tick && !hold && (tmr_reg == PAGE_LAST);
        if (dht_err) begin
            state_next = ST_ERR;
            tmr_next   = '0;
            if (state_reg != ST_ERR)
                ret_next = state_reg;
            if (err_cnt_reg != 8'hFF)
                err_cnt_next = err_cnt_reg + 8'd1;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (accept) begin
                        state_next = ST_TEMP;
                        tmr_next   = '0;
                    end
                end
                ST_TEMP, ST_HUM: begin
                    // Button and expiry together still produce a single advance.
                    if (btn_next || page_expire) begin
                        state_next = (state_reg == ST_TEMP) ? ST_HUM : ST_TEMP;
                        tmr_next   = '0;
                    end else if (ms_tick && !hold) begin
                        tmr_next = tmr_reg + 1'b1;
                    end
                end
                ST_ERR: begin
                    if (ms_tick) begin
                        if (tmr_reg == ERR_LAST) begin
                            state_next = ret_reg;
                            tmr_next   = '0;
                        end else begin
                            tmr_next = tmr_reg + 1'b1;
                        end
                    end
                end
                default: state_next = ST_WAIT;
            endcase
        end
    end

    // Display values are derived from next-state values so they land with the state change.
    logic [7:0] disp_hi_reg, disp_hi_next;
    logic [7:0] disp_lo_reg, disp_lo_next;
    logic       blank_reg, blank_next;

    always_comb begin
        blank_next   = 1'b0;
        disp_hi_next = '0;
        disp_lo_next = '0;
        case (state_next)
            ST_WAIT: blank_next = 1'b1;
            ST_TEMP: begin
                disp_hi_next = sat99(snap_next[0]);
                disp_lo_next = sat99(snap_next[1]);
            end
            ST_HUM: begin
                disp_hi_next = sat99(snap_next[2]);
                disp_lo_next = sat99(snap_next[3]);
            end
            ST_ERR: begin
                disp_hi_next = 8'd99;
                disp_lo_next = sat99(err_cnt_next);
            end
            default: blank_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_WAIT;
            ret_reg     <= ST_WAIT;
            tmr_reg     <= '0;
            err_cnt_reg <= '0;
            disp_hi_reg <= '0;
            disp_lo_reg <= '0;
            blank_reg   <= 1'b1;
        end else begin
            state_reg   <= state_next;
            ret_reg     <= ret_next;
            tmr_reg     <= tmr_next;
            err_cnt_reg <= err_cnt_next;
            disp_hi_reg <= disp_hi_next;
            disp_lo_reg <= disp_lo_next;
            blank_reg   <= blank_next;
        end
    end

    assign disp_hi = disp_hi_reg;
    assign disp_lo = disp_lo_reg;
    assign blank   = blank_reg;
    assign page    = state_reg;

`ifdef FND_SCHED_STALE_EN
    localparam int SW = $clog2(STALE_MS + 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_MS);
    localparam logic [SW-1:0] STALE_PRE = SW'(STALE_MS - 1);

    logic [SW-1:0] stale_cnt_reg;
    logic          stale_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stale_cnt_reg <= '0;
            stale_reg     <= 1'b0;
        end else if (accept) begin
            stale_cnt_reg <= '0;
            stale_reg     <= 1'b0;
        end else if (ms_tick && stale_cnt_reg != STALE_MAX) begin
            stale_cnt_reg <= stale_cnt_reg + 1'b1;
            if (stale_cnt_reg == STALE_PRE)
                stale_reg <= 1'b1;
        end
    end

    assign stale = stale_reg;
`else
    assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Self-checking bench for fnd_display_scheduler: directed scenarios plus random traffic
// compared every cycle against a millisecond-level behavioural model.
module tb_fnd_display_scheduler;

    localparam int CLK_PER_MS = 10;
    localparam int PAGE_MS    = 4;
    localparam int ERR_MS     = 3;
    localparam int STALE_MS   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dht_valid = 1'b0;
    logic       dht_err = 1'b0;
    logic [7:0] humidity_inc = '0;
    logic [7:0] humidity_dec = '0;
    logic [7:0] temperature_inc = '0;
    logic [7:0] temperature_dec = '0;
    logic       btn_next = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] disp_hi, disp_lo;
    logic [1:0] page;
    logic       blank, stale;

    fnd_display_scheduler #(
        .CLK_PER_MS(CLK_PER_MS),
        .PAGE_MS   (PAGE_MS),
        .ERR_MS    (ERR_MS),
        .STALE_MS  (STALE_MS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dht_valid      (dht_valid),
        .dht_err        (dht_err),
        .humidity_inc   (humidity_inc),
        .humidity_dec   (humidity_dec),
        .temperature_inc(temperature_inc),
        .temperature_dec(temperature_dec),
        .btn_next       (btn_next),
        .hold           (hold),
        .disp_hi        (disp_hi),
        .disp_lo        (disp_lo),
        .page           (page),
        .blank          (blank),
        .stale          (stale)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: page code, elapsed ms in the current page, data age in ms.
    int m_page, m_ret, m_elapsed, m_err_cnt, m_cyc, m_age;
    int m_snap[4];

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    task automatic model_reset();
        m_page = 0; m_ret = 0; m_elapsed = 0; m_err_cnt = 0; m_cyc = 0; m_age = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 0;
    endtask

    task automatic model_step(input bit v, input bit e, input bit b, input bit h);
        bit tick;
        bit accept;
        tick   = (m_cyc % CLK_PER_MS) == CLK_PER_MS - 1;
        accept = v && !e;
        m_cyc++;
        if (accept)      m_age = 0;
        else if (tick)   m_age = (m_age + 1 > STALE_MS) ? STALE_MS : m_age + 1;
        if (e) begin
            if (m_page != 3) m_ret = m_page;
            m_page = 3;
            m_elapsed = 0;
            m_err_cnt = (m_err_cnt == 255) ? 255 : m_err_cnt + 1;
        end else if (m_page == 0) begin
            if (accept) begin m_page = 1; m_elapsed = 0; end
        end else if (m_page == 3) begin
            if (tick) m_elapsed++;
            if (m_elapsed == ERR_MS) begin m_page = m_ret; m_elapsed = 0; end
        end else begin
            if (b || (tick && !h && m_elapsed == PAGE_MS - 1)) begin
                m_page = 3 - m_page;
                m_elapsed = 0;
            end else if (tick && !h) begin
                m_elapsed++;
            end
        end
        if (accept) begin
            m_snap[0] = temperature_inc; m_snap[1] = temperature_dec;
            m_snap[2] = humidity_inc;    m_snap[3] = humidity_dec;
        end
    endtask

    task automatic compare_all();
        int eh, el;
        case (m_page)
            1:       begin eh = sat(m_snap[0]); el = sat(m_snap[1]); end
            2:       begin eh = sat(m_snap[2]); el = sat(m_snap[3]); end
            3:       begin eh = 99; el = sat(m_err_cnt); end
            default: begin eh = 0; el = 0; end
        endcase
        check("page", page, m_page);
        check("blank", blank, (m_page == 0) ? 1 : 0);
        check("disp_hi", disp_hi, eh);
        check("disp_lo", disp_lo, el);
`ifdef FND_SCHED_STALE_EN
        check("stale", stale, (m_age >= STALE_MS) ? 1 : 0);
`else
        check("stale", stale, 0);
`endif
    endtask

    task automatic step(input bit v, input bit e, input bit b, input bit h);
        dht_valid = v; dht_err = e; btn_next = b; hold = h;
        @(posedge clk);
        model_step(v, e, b, h);
        #1;
        compare_all();
        dht_valid = 1'b0; dht_err = 1'b0; btn_next = 1'b0;
    endtask

    task automatic idle(input int n, input bit h);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, h);
    endtask

    task automatic set_data(input int ti, input int td, input int hi, input int hd);
        temperature_inc = 8'(ti); temperature_dec = 8'(td);
        humidity_inc    = 8'(hi); humidity_dec    = 8'(hd);
    endtask

    task automatic note(input string what);
        $display("txn %-18s page=%0d hi=%0d lo=%0d blank=%0d stale=%0d",
                 what, page, disp_hi, disp_lo, blank, stale);
    endtask

    initial begin
        bit hold_r;
        bit v, e, b;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        check("rst_page", page, 0);
        check("rst_blank", blank, 1);
        check("rst_hi", disp_hi, 0);
        check("rst_lo", disp_lo, 0);
        check("rst_stale", stale, 0);
        note("reset");

        // First reading enters TEMP, then auto-rotates to HUM.
        set_data(25, 3, 61, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("first_page", page, 1);
        check("first_hi", disp_hi, 25);
        check("first_lo", disp_lo, 3);
        check("first_blank", blank, 0);
        note("first valid");
        idle(40, 1'b0);
        check("rot_page", page, 2);
        check("rot_hi", disp_hi, 61);
        check("rot_lo", disp_lo, 0);
        note("auto rotate");

        // Hold freezes rotation; the button still advances.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("btn_to_temp", page, 1);
        idle(200, 1'b1);
        check("hold_page", page, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("hold_btn_page", page, 2);
        note("hold + btn");

        // Error page, extension by a second error, return to HUM.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("err_page", page, 3);
        check("err_hi", disp_hi, 99);
        check("err_lo", disp_lo, 1);
        idle(5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("err2_page", page, 3);
        check("err2_lo", disp_lo, 2);
        idle(20, 1'b0);
        check("err_ext_page", page, 3);
        idle(10, 1'b0);
        check("err_ret_page", page, 2);
        note("error return");

        // Valid and error together: error wins, no snapshot.
        set_data(40, 7, 61, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ve_page", page, 3);
        check("ve_lo", disp_lo, 3);
        idle(30, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ve_temp_page", page, 1);
        check("ve_snap_hi", disp_hi, 25);
        check("ve_snap_lo", disp_lo, 3);
        note("valid+err");

        // Stale flag after a long gap, cleared by the next valid.
`ifdef FND_SCHED_STALE_EN
        check("stale_set", stale, 1);
`else
        check("stale_off", stale, 0);
`endif
        set_data(150, 5, 61, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_hi", disp_hi, 99);
        check("sat_lo", disp_lo, 5);
        check("stale_clr", stale, 0);
        note("saturate");

        // Asynchronous reset in the middle of ERR.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_page", page, 3);
        #2 rst = 1'b0;
        #1;
        check("arst_page", page, 0);
        check("arst_blank", blank, 1);
        check("arst_hi", disp_hi, 0);
        check("arst_lo", disp_lo, 0);
        check("arst_stale", stale, 0);
        note("async reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("cnt_restart_lo", disp_lo, 1);
        idle(30, 1'b0);
        check("err_to_wait", page, 0);
        note("err from wait");

        // Random traffic against the model.
        hold_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) hold_r = ~hold_r;
            v = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 149) == 0);
            b = ($urandom_range(0, 29) == 0);
            if (v)
                set_data($urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255), $urandom_range(0, 255));
            step(v, e, b, hold_r);
        end
        note("random done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_display_scheduler.md
FND_DISPLAY_SCHEDULER -- requirements
Module: fnd_display_scheduler

Interface
REQ-001 Parameter CLK_PER_MS, default 100000: clk cycles per 1 ms tick.
REQ-002 Parameter PAGE_MS, default 2000: ms each page is shown before auto-rotation.
REQ-003 Parameter ERR_MS, default 3000: ms the error page is shown.
REQ-004 Parameter STALE_MS, default 5000: ms without new data before stale is flagged.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 dht_valid  input  1  single-cycle pulse; the four data inputs are valid this cycle.
REQ-008 dht_err  input  1  single-cycle pulse; sensor transaction failed.
REQ-009 humidity_inc, humidity_dec, temperature_inc, temperature_dec  input  8 each  sensor integer/decimal parts.
REQ-010 btn_next  input  1  debounced single-cycle pulse; manual page advance.
REQ-011 hold  input  1  level; freezes auto-rotation.
REQ-012 disp_hi  output  8  value for the upper two FND digits.
REQ-013 disp_lo  output  8  value for the lower two FND digits.
REQ-014 page  output  2  current state code: 0 WAIT, 1 TEMP, 2 HUM, 3 ERR.
REQ-015 blank  output  1  1 = FND must be blanked.
REQ-016 stale  output  1  1 = displayed data is older than STALE_MS.

Function
REQ-017 Prescaler counts 0..CLK_PER_MS-1 and emits a one-cycle ms_tick on wrap; it runs freely, including while hold=1.
REQ-018 Snapshot registers capture all four data inputs together on dht_valid=1 and dht_err=0; partial updates are forbidden.
REQ-019 FSM states: WAIT, TEMP, HUM, ERR; reset state is WAIT.
REQ-020 WAIT: blank=1, disp_hi=disp_lo=0; first accepted dht_valid -> TEMP.
REQ-021 TEMP: disp_hi=temperature_inc snapshot, disp_lo=temperature_dec snapshot.
REQ-022 HUM: disp_hi=humidity_inc snapshot, disp_lo=humidity_dec snapshot.
REQ-023 TEMP<->HUM advance occurs when the page counter reaches PAGE_MS-1 on an ms_tick, or when btn_next=1.
REQ-024 Page counter clears to 0 on every state change; it does not advance while hold=1; btn_next still advances while hold=1.
REQ-025 Simultaneous expiry and btn_next cause exactly one advance.
REQ-026 dht_err in any state -> ERR; return state is recorded (WAIT, TEMP or HUM); the 8-bit err_cnt increments, saturating at 255.
REQ-027 ERR: blank=0, disp_hi=99, disp_lo=min(err_cnt,99); btn_next and hold are ignored; after ERR_MS ms -> return state.
REQ-028 dht_err in ERR restarts the ERR timer and increments err_cnt.
REQ-029 dht_valid and dht_err in the same cycle: error wins, no snapshot.
REQ-030 dht_valid in ERR updates the snapshot and does not leave ERR.
REQ-031 Any displayed data value >99 is saturated to 99.
REQ-032 All outputs are registered; disp_hi, disp_lo, page and blank reflect a state change or snapshot one clk after the causing edge.

Reset
REQ-033 rst=0 asynchronously forces WAIT; all counters, snapshots and err_cnt go to 0; blank=1, disp_hi=disp_lo=0, page=0, stale=0.
REQ-034 Reset asserted mid-page or mid-ERR abandons the state; after release the block restarts in WAIT and needs a new dht_valid.

Configuration
REQ-035 Macro FND_SCHED_STALE_EN defined: a stale counter counts ms_ticks since the last accepted snapshot; stale=1 when it reaches STALE_MS and stays 1 until the next accepted dht_valid, which clears it on that edge; the counter saturates.
REQ-036 Macro FND_SCHED_STALE_EN undefined: no stale counter is built, and stale is tied to 0.

Verification (CLK_PER_MS=10, PAGE_MS=4, ERR_MS=3, STALE_MS=20)
REQ-037 Reset, then dht_valid with temperature 25.3 and humidity 61.0 -> page=1, disp_hi=25, disp_lo=3, blank=0 one cycle later; after 40 clk -> page=2, disp_hi=61, disp_lo=0.
REQ-038 Hold=1 for 200 clk in TEMP -> page stays 1; btn_next pulse -> page=2 next cycle.
REQ-039 dht_err in HUM -> page=3, disp_hi=99, disp_lo=1; after 30 clk -> page=2; a second error during ERR extends ERR and gives disp_lo=2.
REQ-040 dht_valid and dht_err in the same cycle with temperature 40 -> page=3 and the snapshot is unchanged; temperature_inc=150 on a valid pulse -> disp_hi=99 in TEMP.
REQ-041 With FND_SCHED_STALE_EN defined, no dht_valid for 200 clk -> stale=1; the next dht_valid -> stale=0; with the macro undefined, stale stays 0.
REQ-042 rst=0 pulsed asynchronously mid-ERR -> page=0, blank=1, disp_hi=disp_lo=0 immediately; err_cnt restarts from 0.
